// File: rtl/serial_borrow_subtractor.sv
// Bit-serial ripple-borrow subtractor: D = A - B - bin, one bit per clock, LSB first.
// A start/busy/done handshake launches an operation and publishes registered result flags.
module serial_borrow_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int IDX_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, b_q, diff_q;
   logic [IDX_W-1:0]   idx_q;
   logic               br_q;
   logic [WIDTH-1:0]   d_q;
   logic               bout_q, ovf_q, zero_q;

   logic               last_bit;
   logic               dbit, br_next;
   logic [WIDTH-1:0]   diff_next;

   function automatic logic fs_diff(input logic x, input logic y, input logic br);
      return x ^ y ^ br;
   endfunction

   function automatic logic fs_borrow(input logic x, input logic y, input logic br);
      return (~x & y) | (~(x ^ y) & br);
   endfunction

   assign last_bit  = (idx_q == IDX_W'(WIDTH - 1));
   assign dbit      = fs_diff(a_q[0], b_q[0], br_q);
   assign br_next   = fs_borrow(a_q[0], b_q[0], br_q);
   // Difference bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
   assign diff_next = {dbit, diff_q[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (last_bit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == SHIFT);
      done = (state_q == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         diff_q <= '0;
         idx_q  <= '0;
         br_q   <= 1'b0;
         d_q    <= '0;
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q    <= a;
                  b_q    <= b;
                  br_q   <= bin;
                  idx_q  <= '0;
                  diff_q <= '0;
               end
            end
            SHIFT: begin
               a_q    <= a_q >> 1;
               b_q    <= b_q >> 1;
               br_q   <= br_next;
               diff_q <= diff_next;
               idx_q  <= idx_q + IDX_W'(1);
               // On the MSB, br_q is the borrow into the MSB and br_next the borrow out.
               if (last_bit) begin
                  d_q    <= diff_next;
                  bout_q <= br_next;
                  ovf_q  <= br_q ^ br_next;
                  zero_q <= (diff_next == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign d    = d_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule
